// File: rtl/adder_pkg.sv
// Shared types for the adder family: operation select and the result flag bundle.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } adder_flags_t;

endpackage

// File: rtl/adder_segment.sv
// SEG-bit ripple-carry slice made of full_adder cells; also exposes the carry
// into its most significant bit so the final slice can derive signed overflow.
module adder_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[SEG];
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell; the ripple segments are built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// N-bit add/subtract split into N/SEG carry-pipelined stages with a valid/ready
// wrapper; every stage advances together, results leave fully deskewed.
//
// Handshake: a beat is accepted on a rising edge where in_valid && in_ready; a
// result transfers on a rising edge where out_valid && out_ready. in_ready is
// combinational (!out_valid || out_ready); a stalled result holds all outputs.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  op_e          op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int STAGES = (SEG > 0) ? N / SEG : 1;

  if (N < 1 || SEG < 1 || (N % ((SEG > 0) ? SEG : 1)) != 0) begin : g_bad_params
    $error("pipelined_adder: N must be a positive multiple of SEG");
  end

  logic               enable;
  logic [N-1:0]       b_eff;
  logic               c_eff;
  logic               out_valid_q;
  logic [N-1:0]       sum_q;
  adder_flags_t       flags_q;

  assign enable   = !out_valid_q || out_ready;
  assign in_ready = enable;

  // Subtraction is a + ~b + 1, so the inversion happens once at the input.
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c_eff = (op == OP_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int CW = N - k * SEG;     // operand bits not yet added
    localparam int SW = (k + 1) * SEG;   // sum bits complete after this stage

    logic [CW-1:0]  a_cur;
    logic [CW-1:0]  b_cur;
    logic           c_cur;
    logic           v_cur;
    logic [SEG-1:0] seg_sum;
    logic           seg_cout;
    logic [SW-1:0]  s_cat;

    if (k == 0) begin : g_src
      assign a_cur = a;
      assign b_cur = b_eff;
      assign c_cur = c_eff;
      assign v_cur = in_valid;
      assign s_cat = seg_sum;
    end else begin : g_src
      assign a_cur = g_stage[k-1].g_pipe.a_q;
      assign b_cur = g_stage[k-1].g_pipe.b_q;
      assign c_cur = g_stage[k-1].g_pipe.c_q;
      assign v_cur = g_stage[k-1].g_pipe.v_q;
      assign s_cat = {seg_sum, g_stage[k-1].g_pipe.s_q};
    end

    if (k < STAGES - 1) begin : g_pipe
      logic [CW-SEG-1:0] a_q;
      logic [CW-SEG-1:0] b_q;
      logic [SW-1:0]     s_q;
      logic              c_q;
      logic              v_q;
      logic              cmsb_unused;

      adder_segment #(.SEG(SEG)) u_seg (
        .a   (a_cur[SEG-1:0]),
        .b   (b_cur[SEG-1:0]),
        .cin (c_cur),
        .sum (seg_sum),
        .cout(seg_cout),
        .cmsb(cmsb_unused)
      );

      // Upper operand slices ride along; finished low sum slices accumulate.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          s_q <= '0;
          a_q <= '0;
          b_q <= '0;
        end else if (enable) begin
          v_q <= v_cur;
          c_q <= seg_cout;
          s_q <= s_cat;
          a_q <= a_cur[CW-1:SEG];
          b_q <= b_cur[CW-1:SEG];
        end
      end
    end else begin : g_out
      logic cmsb;

      adder_segment #(.SEG(SEG)) u_seg (
        .a   (a_cur[SEG-1:0]),
        .b   (b_cur[SEG-1:0]),
        .cin (c_cur),
        .sum (seg_sum),
        .cout(seg_cout),
        .cmsb(cmsb)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          flags_q     <= '0;
        end else if (enable) begin
          out_valid_q  <= v_cur;
          sum_q        <= s_cat;
          flags_q.cout <= seg_cout;
          flags_q.ovf  <= cmsb ^ seg_cout;
          flags_q.zero <= (s_cat == '0);
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (N=16, SEG=4): directed vector table, random
// back-to-back traffic, bubbles, output stall and mid-flight reset.
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int N   = 16;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  op_e          op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  always #5 clk = ~clk;

  pipelined_adder #(.N(N), .SEG(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  int             checks = 0;
  int             errors = 0;
  logic [N+2:0]   exp_q[$];       // {cout, ovf, zero, sum}
  logic [LAT-1:0] acc_sr;
  logic           chk_lat;
  logic           got_out;
  logic [N+2:0]   got_val;

  typedef struct {
    op_e         op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [N+2:0] model(input op_e o, input logic [15:0] x,
                                         input logic [15:0] y, input logic c);
    int          ux = x;
    int          uy = y;
    int          sx = $signed(x);
    int          sy = $signed(y);
    int          t;
    int          st;
    logic        co;
    logic        ov;
    logic [15:0] s;
    if (o == OP_ADD) begin
      t  = ux + uy + int'(c);
      st = sx + sy + int'(c);
      co = (t > 65535);
    end else begin
      t  = ux - uy;
      st = sx - sy;
      co = (ux >= uy);
    end
    s  = t[15:0];
    ov = (st > 32767) || (st < -32768);
    return {co, ov, (s == 16'h0000), s};
  endfunction

  // Scoreboard step, evaluated mid-cycle (negedge) for the coming rising edge.
  task automatic mon();
    logic         acc;
    logic [N+2:0] e;
    if (!rst_n) begin
      exp_q.delete();
      acc_sr = '0;
      return;
    end
    if (chk_lat) chk("valid_latency", {31'd0, out_valid}, {31'd0, acc_sr[LAT-1]});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum 0x%0h, expected no result", sum);
      end else begin
        e = exp_q.pop_front();
        chk("result", {13'd0, cout, ovf, zero, sum}, {13'd0, e});
        got_out = 1'b1;
        got_val = {cout, ovf, zero, sum};
      end
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(op, a, b, cin));
    acc_sr = {acc_sr[LAT-2:0], acc};
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    a   = N'($urandom_range(0, 65535));
    b   = N'($urandom_range(0, 65535));
    cin = 1'($urandom_range(0, 1));
    op  = op_e'($urandom_range(0, 1));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [N+3:0] snap;

    vecs[0] = '{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{OP_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{OP_ADD, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_SUB, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{OP_ADD, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{OP_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{OP_ADD, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = OP_ADD;
    out_ready = 1'b1; chk_lat = 1'b0; acc_sr = '0; got_out = 1'b0; got_val = '0;
    repeat (3) tick();

    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_flags", {29'd0, cout, ovf, zero}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
    chk_lat = 1'b1;

    // Directed table, one beat at a time.
    for (int i = 0; i < 9; i++) begin
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      got_out = 1'b0;
      for (int w = 0; w < 20 && !got_out; w++) tick();
      if (!got_out) begin
        chk("vec_timeout", 32'd0, 32'd1);
      end else begin
        chk("vec_sum", {16'd0, got_val[N-1:0]}, {16'd0, vecs[i].s});
        chk("vec_cout", {31'd0, got_val[N+2]}, {31'd0, vecs[i].co});
        chk("vec_ovf", {31'd0, got_val[N+1]}, {31'd0, vecs[i].ov});
        chk("vec_zero", {31'd0, got_val[N]}, {31'd0, vecs[i].z});
      end
    end

    // Back-to-back random beats.
    for (int i = 0; i < 100; i++) begin
      rand_beat();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (8) tick();
    chk("drain_random", exp_q.size(), 32'd0);

    // Alternating bubbles.
    for (int i = 0; i < 40; i++) begin
      rand_beat();
      in_valid = (i % 2 == 0);
      tick();
    end
    in_valid = 1'b0;
    repeat (8) tick();
    chk("drain_bubbles", exp_q.size(), 32'd0);

    // Full pipe, then hold out_ready low for three cycles.
    chk_lat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_beat();
      in_valid = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    #1;
    snap = {out_valid, cout, ovf, zero, sum};
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready_hold", {31'd0, in_ready}, 32'd0);
      chk("stall_outputs_hold", {12'd0, out_valid, cout, ovf, zero, sum}, {12'd0, snap});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();
    chk("drain_stall", exp_q.size(), 32'd0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_sum", {16'd0, sum}, 32'd0);
    chk("midreset_flags", {29'd0, cout, ovf, zero}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("ready_after_midreset", {31'd0, in_ready}, 32'd1);
    chk_lat = 1'b1;
    repeat (8) tick();
    chk("no_stale_results", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
